// File: rtl/ocs_slot_sched.sv
// ============================================================================
// ocs_slot_sched : OCS DATA/CONFIG slot scheduler with wrapping multi-bit IDs
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ocs_slot_sched #(
  parameter int          P_SLOT_NUM     = 4,
  parameter int          P_ID_W         = 2,
  parameter int          P_CHNL_NUM     = 2,
  parameter int          P_CNT_W        = 16,
  parameter int unsigned P_SLOT_LEN     = 32'h5CD0,
  parameter int unsigned P_CONFIG_DELAY = 32'h0960
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [P_CHNL_NUM-1:0] i_chnl_ready,
  input  logic                  i_len_wr,
  input  logic [P_CNT_W-1:0]    i_slot_len,
  input  logic [P_CNT_W-1:0]    i_cfg_delay,
  output logic [P_ID_W-1:0]     o_slot_id,
  output logic [P_ID_W-1:0]     o_next_slot_id,
  output logic                  o_slot_start,
  output logic                  o_config_start,
  output logic                  o_data_win,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CONFIG = 2'd2
  } state_t;

  localparam logic [P_ID_W-1:0]  LAST_ID = P_ID_W'(P_SLOT_NUM - 1);
  localparam logic [P_CNT_W-1:0] ONE     = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] DEF_LEN = P_CNT_W'(P_SLOT_LEN);
  localparam logic [P_CNT_W-1:0] DEF_CFG = P_CNT_W'(P_CONFIG_DELAY);

  state_t               state, state_nxt;
  logic [P_CNT_W-1:0]   cnt, cnt_nxt;
  logic [P_CNT_W-1:0]   act_len, act_cfg, shd_len, shd_cfg;
  logic                 stop_req;
  logic                 all_rdy;
  logic                 go_data, go_config, go_idle;

  function automatic logic [P_ID_W-1:0] wrap_id(input logic [P_ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + P_ID_W'(1);
  endfunction

  assign all_rdy = &i_chnl_ready;

  // Counting only advances on ticks; a missing tick freezes the phase in place.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_data   = 1'b0;
    go_config = 1'b0;
    go_idle   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable && all_rdy) begin
          state_nxt = ST_DATA;
          cnt_nxt   = '0;
          go_data   = 1'b1;
        end
      end
      ST_DATA: begin
        if (all_rdy) begin
          if (cnt == act_len - ONE) begin
            state_nxt = ST_CONFIG;
            cnt_nxt   = '0;
            go_config = 1'b1;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      ST_CONFIG: begin
        if (all_rdy) begin
          if (cnt == act_cfg - ONE) begin
            cnt_nxt = '0;
            if (stop_req || !i_enable) begin
              state_nxt = ST_IDLE;
              go_idle   = 1'b1;
            end else begin
              state_nxt = ST_DATA;
              go_data   = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      o_slot_id      <= '0;
      o_next_slot_id <= P_ID_W'(1);
      o_slot_start   <= 1'b0;
      o_config_start <= 1'b0;
      o_data_win     <= 1'b0;
      o_busy         <= 1'b0;
      act_len        <= DEF_LEN;
      act_cfg        <= DEF_CFG;
      shd_len        <= DEF_LEN;
      shd_cfg        <= DEF_CFG;
      stop_req       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      o_slot_start   <= go_data;
      o_config_start <= go_config;
      o_data_win     <= (state_nxt == ST_DATA);
      o_busy         <= (state_nxt != ST_IDLE);

      // Lengths only take effect at DATA entry so a phase never changes length mid-way.
      if (go_data) begin
        act_len <= shd_len;
        act_cfg <= shd_cfg;
        if (state == ST_IDLE) begin
          o_slot_id      <= '0;
          o_next_slot_id <= P_ID_W'(1);
        end else begin
          o_slot_id      <= o_next_slot_id;
          o_next_slot_id <= wrap_id(o_next_slot_id);
        end
      end

      if (i_len_wr) begin
        shd_len <= (i_slot_len == '0) ? ONE : i_slot_len;
        shd_cfg <= (i_cfg_delay == '0) ? ONE : i_cfg_delay;
      end

      if (go_idle || state == ST_IDLE) begin
        stop_req <= 1'b0;
      end else if (!i_enable) begin
        stop_req <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ocs_slot_sched.sv
// ============================================================================
// tb_ocs_slot_sched : randomized and directed bench against a phase-level model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ocs_slot_sched;

  localparam int PH_IDLE = 0;
  localparam int PH_DATA = 1;
  localparam int PH_CFG  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  rdy = 2'b11;
  logic [15:0] len_in = '0;
  logic [15:0] cfg_in = '0;

  logic [1:0] a_id, a_nid, b_id, b_nid;
  logic       a_ss, a_cs, a_dw, a_busy;
  logic       b_ss, b_cs, b_dw, b_busy;

  always #5 clk = ~clk;

  ocs_slot_sched #(
    .P_SLOT_NUM(3), .P_ID_W(2), .P_CHNL_NUM(2), .P_CNT_W(16),
    .P_SLOT_LEN(8), .P_CONFIG_DELAY(3)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_chnl_ready(rdy),
    .i_len_wr(wr), .i_slot_len(len_in), .i_cfg_delay(cfg_in),
    .o_slot_id(a_id), .o_next_slot_id(a_nid), .o_slot_start(a_ss),
    .o_config_start(a_cs), .o_data_win(a_dw), .o_busy(a_busy)
  );

  ocs_slot_sched #(
    .P_SLOT_NUM(4), .P_ID_W(2), .P_CHNL_NUM(2), .P_CNT_W(16),
    .P_SLOT_LEN(8), .P_CONFIG_DELAY(3)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_chnl_ready(rdy),
    .i_len_wr(wr), .i_slot_len(len_in), .i_cfg_delay(cfg_in),
    .o_slot_id(b_id), .o_next_slot_id(b_nid), .o_slot_start(b_ss),
    .o_config_start(b_cs), .o_data_win(b_dw), .o_busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: phase plus ticks remaining in it, per DUT instance
  int nslots[2] = '{3, 4};
  int m_phase[2], m_left[2], m_id[2], m_nid[2];
  int m_len[2], m_cfg[2], m_sl[2], m_sc[2];
  bit m_stop[2], m_ss[2], m_cs[2];

  function automatic void model_reset(input int k);
    m_phase[k] = PH_IDLE; m_left[k] = 0; m_id[k] = 0; m_nid[k] = 1;
    m_len[k] = 8; m_cfg[k] = 3; m_sl[k] = 8; m_sc[k] = 3;
    m_stop[k] = 0; m_ss[k] = 0; m_cs[k] = 0;
  endfunction

  function automatic void model_tick(input int k);
    int osl, osc;
    bit tick, enter, was_busy;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    osl = m_sl[k]; osc = m_sc[k];
    tick = &rdy; enter = 0; was_busy = (m_phase[k] != PH_IDLE);
    m_ss[k] = 0; m_cs[k] = 0;
    case (m_phase[k])
      PH_IDLE: if (en && tick) begin m_id[k] = 0; m_nid[k] = 1; enter = 1; end
      PH_DATA: if (tick) begin
        m_left[k]--;
        if (m_left[k] == 0) begin m_phase[k] = PH_CFG; m_left[k] = m_cfg[k]; m_cs[k] = 1; end
      end
      default: if (tick) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          if (m_stop[k] || !en) m_phase[k] = PH_IDLE;
          else begin m_id[k] = m_nid[k]; m_nid[k] = (m_nid[k] + 1) % nslots[k]; enter = 1; end
        end
      end
    endcase
    if (enter) begin
      m_phase[k] = PH_DATA; m_len[k] = osl; m_cfg[k] = osc; m_left[k] = osl; m_ss[k] = 1;
    end
    if (m_phase[k] == PH_IDLE) m_stop[k] = 0;
    else if (was_busy && !en) m_stop[k] = 1;
    if (wr) begin
      m_sl[k] = (len_in == 0) ? 1 : int'(len_in);
      m_sc[k] = (cfg_in == 0) ? 1 : int'(cfg_in);
    end
  endfunction

  function automatic logic [7:0] mdl_vec(input int k);
    return {2'(m_id[k]), 2'(m_nid[k]), m_ss[k], m_cs[k],
            m_phase[k] == PH_DATA, m_phase[k] != PH_IDLE};
  endfunction

  function automatic logic [7:0] dut_vec(input int k);
    return (k == 0) ? {a_id, a_nid, a_ss, a_cs, a_dw, a_busy}
                    : {b_id, b_nid, b_ss, b_cs, b_dw, b_busy};
  endfunction

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_tick(k);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; wr = 1'b0; rdy = 2'b11;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== 8'b00_01_0000) begin
        errors++; $display("FAIL reset_vals dut%0d got=%b exp=%b", k, dut_vec(k), 8'b00_01_0000);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== mdl_vec(k)) begin
        errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
      end
    end
  endtask

  task automatic test_basic();
    int ssq[$], idq[$], csq[$], dq[$];
    int dw_run;
    int exp_ids[5] = '{0, 1, 2, 0, 1};
    dw_run = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
        end
      end
      if (a_ss) begin ssq.push_back(cyc); idq.push_back(int'(a_id)); end
      if (a_cs) csq.push_back(cyc);
      if (a_dw) dw_run++;
      else if (dw_run != 0) begin dq.push_back(dw_run); dw_run = 0; end
    end
    checks++;
    if (ssq.size() < 5 || csq.size() < 4 || dq.size() < 1) begin
      errors++; $display("FAIL basic_count slot_starts=%0d config_starts=%0d need 5/4", ssq.size(), csq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (idq[i] != exp_ids[i]) begin
          errors++; $display("FAIL basic_id slot%0d got=%0d exp=%0d", i, idq[i], exp_ids[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (ssq[i] - ssq[i-1] != 11) begin
          errors++; $display("FAIL basic_period slot%0d got=%0d exp=11", i, ssq[i] - ssq[i-1]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (csq[i] - ssq[i] != 8) begin
          errors++; $display("FAIL basic_cfg_offset slot%0d got=%0d exp=8", i, csq[i] - ssq[i]);
        end
      end
      checks++;
      if (dq[0] != 8) begin
        errors++; $display("FAIL basic_data_win got=%0d exp=8", dq[0]);
      end
    end
  endtask

  task automatic test_stall();
    int dw_len, pulses;
    bit seen;
    do_reset();
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (a_ss) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_start timeout got=0 exp=1"); end
    dw_len = 1; pulses = 0;
    for (int i = 0; i < 40 && a_dw; i++) begin
      rdy = (i >= 2 && i < 7) ? 2'b01 : 2'b11;
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
        end
      end
      if (a_dw) dw_len++;
      if (a_ss && a_dw) pulses++;
    end
    checks++;
    if (dw_len != 13) begin errors++; $display("FAIL stall_data_len got=%0d exp=13", dw_len); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL stall_pulses got=%0d exp=0", pulses); end
    do_reset();
    rdy = 2'b01; en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL stall_idle busy_a=%b busy_b=%b exp=0", a_busy, b_busy);
    end
    rdy = 2'b11;
  endtask

  task automatic test_len_reload();
    int dq[$], cq[$];
    int dw_run, cf_run, n_ss;
    int exp_d[3] = '{8, 4, 1};
    int exp_c[3] = '{3, 2, 2};
    dw_run = 0; cf_run = 0; n_ss = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
        end
      end
      if (a_dw) dw_run++;
      else if (dw_run != 0) begin dq.push_back(dw_run); dw_run = 0; end
      if (a_busy && !a_dw) cf_run++;
      else if (cf_run != 0) begin cq.push_back(cf_run); cf_run = 0; end
      if (a_ss) n_ss++;
      wr = 1'b0;
      if (a_ss && n_ss == 1) begin wr = 1'b1; len_in = 16'd4; cfg_in = 16'd2; end
      if (a_ss && n_ss == 2) begin wr = 1'b1; len_in = 16'd0; cfg_in = 16'd2; end
    end
    checks++;
    if (dq.size() < 3 || cq.size() < 3) begin
      errors++; $display("FAIL reload_count data_runs=%0d cfg_runs=%0d exp>=3", dq.size(), cq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dq[i] != exp_d[i] || cq[i] != exp_c[i]) begin
          errors++; $display("FAIL reload_len slot%0d got=%0d/%0d exp=%0d/%0d", i, dq[i], cq[i], exp_d[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_stop();
    int n_ss, extra_ss;
    bit went_idle;
    n_ss = 0; extra_ss = 0; went_idle = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 40 && n_ss < 2; i++) begin
      step();
      if (a_ss) n_ss++;
    end
    checks++;
    if (n_ss != 2) begin errors++; $display("FAIL stop_slot1 timeout got=%0d exp=2", n_ss); end
    step(); step();
    en = 1'b0;
    step();
    en = 1'b1;  // sticky: the stop request must survive enable returning high
    for (int i = 0; i < 30 && !went_idle; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
        end
      end
      if (a_ss) extra_ss++;
      if (!a_busy) went_idle = 1;
    end
    checks++;
    if (!went_idle) begin errors++; $display("FAIL stop_idle timeout busy=%b exp=0", a_busy); end
    checks++;
    if (extra_ss != 0) begin errors++; $display("FAIL stop_extra_start got=%0d exp=0", extra_ss); end
    checks++;
    if (a_id !== 2'd1) begin errors++; $display("FAIL stop_id_hold got=%0d exp=1", a_id); end
    step();
    checks++;
    if (a_ss !== 1'b1 || a_id !== 2'd0 || a_nid !== 2'd1) begin
      errors++; $display("FAIL stop_restart ss=%b id=%0d nid=%0d exp ss=1 id=0 nid=1", a_ss, a_id, a_nid);
    end
  endtask

  task automatic test_reset_mid_config();
    int dw_run;
    bit seen;
    seen = 0; dw_run = 0;
    do_reset();
    en = 1'b1; wr = 1'b1; len_in = 16'd5; cfg_in = 16'd4;
    step();
    wr = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (a_cs) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstcfg_config timeout got=0 exp=1"); end
    step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      checks++;
      if (dut_vec(k) !== 8'b00_01_0000) begin
        errors++; $display("FAIL rstcfg_async dut%0d got=%b exp=%b", k, dut_vec(k), 8'b00_01_0000);
      end
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
        end
      end
      if (a_dw) dw_run++;
      else if (dw_run != 0) seen = 1;
    end
    checks++;
    if (dw_run != 8) begin errors++; $display("FAIL rstcfg_default_len got=%0d exp=8", dw_run); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 99) < 97);
      rdy    = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
      wr     = ($urandom_range(0, 19) == 0);
      len_in = 16'($urandom_range(0, 6));
      cfg_in = 16'($urandom_range(0, 4));
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++; $display("FAIL model dut%0d cyc=%0d got=%b exp=%b", k, cyc, dut_vec(k), mdl_vec(k));
        end
      end
      checks++;
      if (a_id >= 2'd3 || a_nid >= 2'd3) begin
        errors++; $display("FAIL rand_id_range cyc=%0d id=%0d nid=%0d exp<3", cyc, a_id, a_nid);
      end
      checks++;
      if (int'(b_nid) != (int'(b_id) + 1) % 4) begin
        errors++; $display("FAIL rand_next_id cyc=%0d nid=%0d exp=%0d", cyc, b_nid, (int'(b_id) + 1) % 4);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    test_reset();
    test_basic();
    test_stall();
    test_len_reload();
    test_stop();
    test_reset_mid_config();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ocs_slot_sched.md
Name: ocs_slot_sched

Overview:
- Parametrised OCS slot scheduler; next generation of the single-bit slot controller.
- Sequences DATA/CONFIG phases over P_SLOT_NUM slots with a wrapping multi-bit slot ID.
- Timing advances only while all P_CHNL_NUM channels are ready; supports enable/stop and runtime slot-length/config-delay reload at slot boundaries.
- Sits between the optical-switch control plane and the per-port TX schedulers.

Parameters:
P_SLOT_NUM, 4, number of slots per cycle (>=2); ID wraps P_SLOT_NUM-1 -> 0
P_ID_W, 2, slot ID width; must satisfy 2**P_ID_W >= P_SLOT_NUM
P_CHNL_NUM, 2, number of channel-ready inputs
P_CNT_W, 16, phase counter and length width
P_SLOT_LEN, 16'h5CD0, reset default DATA phase length in ready-cycles
P_CONFIG_DELAY, 16'h0960, reset default CONFIG phase length in ready-cycles

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  level; start/continue scheduling
i_chnl_ready  in  P_CHNL_NUM  per-channel link ready
i_len_wr  in  1  pulse; load shadow lengths
i_slot_len  in  P_CNT_W  new DATA length
i_cfg_delay  in  P_CNT_W  new CONFIG length
o_slot_id  out  P_ID_W  current slot ID
o_next_slot_id  out  P_ID_W  ID to be used after the next CONFIG
o_slot_start  out  1  1-cycle pulse, first cycle of each DATA phase
o_config_start  out  1  1-cycle pulse, first cycle of each CONFIG phase
o_data_win  out  1  high throughout DATA
o_busy  out  1  high when state != IDLE

Behaviour:
- all_rdy = AND of i_chnl_ready. "Tick" = cycle with all_rdy=1. All outputs registered.
- Reset (async assert, sync release): state IDLE, cnt=0, o_slot_id=0, o_next_slot_id=1, all pulses/levels 0; active lengths and shadow lengths = parameter defaults; stop_req=0.
- States: IDLE, DATA, CONFIG.
- IDLE -> DATA when i_enable && all_rdy: cnt=0, o_slot_id=0, o_next_slot_id=1, o_slot_start=1 next cycle, o_data_win=1. Shadow lengths are copied to active lengths on every DATA entry.
- DATA: cnt increments on each tick, holds otherwise (pause, no state change).
  - On tick with cnt == act_len-1: -> CONFIG, cnt=0, o_config_start pulse, o_data_win=0.
  - DATA thus lasts exactly act_len ticks.
- CONFIG: same counting. On tick with cnt == act_cfg-1:
  - if stop_req: -> IDLE, stop_req cleared, o_slot_id holds, no pulse, o_busy=0.
  - else: -> DATA, o_slot_id <= o_next_slot_id, o_next_slot_id <= wrap(o_next_slot_id+1), o_slot_start pulse, o_data_win=1.
- wrap(x): x==P_SLOT_NUM-1 ? 0 : x+1; never emits ID >= P_SLOT_NUM.
- Stop: i_enable low while not IDLE sets stop_req (sticky). Current DATA and CONFIG complete; IDLE is entered at the CONFIG end. i_enable re-high does not cancel stop_req. Restart from IDLE always begins at ID 0.
- i_len_wr: latch i_slot_len/i_cfg_delay into shadow regs any cycle. Active values change only at DATA entry, never mid-phase. Simultaneous i_len_wr on a DATA-entry cycle: the old shadow is applied, the new one on the following entry.
- Zero length written: clamped to 1 on load (phase lasts 1 tick).
- all_rdy dropping on a terminal-count cycle: no transition until the next tick.
- Reset asserted mid-phase: immediate return to reset values; no pulse emitted.
- Latency: o_slot_start/o_config_start are high in the first cycle the new state is visible, i.e. the cycle after the terminal tick.

Test Plan:
- P_SLOT_NUM=3, LEN=8, CFG=3, ready=all 1, enable=1 -> slot_start every 11 cycles; IDs 0,1,2,0,1; config_start 8 cycles after each slot_start; data_win high 8 cycles.
- Deassert i_chnl_ready[1] for 5 cycles mid-DATA -> DATA stretches to 13 cycles, cnt frozen, no extra pulses; one channel low from reset keeps IDLE.
- i_len_wr with len=4, cfg=2 during slot 0 DATA -> slot 0 stays 8/3, slot 1 DATA=4 and CONFIG=2; write of len=0 -> DATA of 1 cycle.
- Drop i_enable at cnt=2 of slot 1 DATA -> slot 1 DATA and CONFIG finish, then IDLE, o_busy=0, no slot_start; re-enable -> restart at ID 0.
- Assert i_rst_n low mid-CONFIG -> all outputs 0 the same cycle, o_next_slot_id=1, lengths back to 8/3.
- P_SLOT_NUM=4, P_ID_W=2 for 20 slots -> IDs cycle 0..3, never out of range; o_next_slot_id always equals wrap(o_slot_id).
